count_snapshot_serializer: RTL and testbench
============================================

COUNT_SNAPSHOT_SERIALIZER -- requirements
Module: count_snapshot_serializer

Interface
REQ-001 Parameter: LSB_FIRST, default 1, byte order within each 64-bit word (1 = bits[7:0] first, 0 = bits[63:56] first).
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset; clears all state immediately.
REQ-004 Cap  input  1  capture request; sampled on rising Clk.
REQ-005 Count0  input  64  first primary-counter value (upstream Output0).
REQ-006 Count1  input  64  second primary-counter value (upstream Output1).
REQ-007 OutData  output  8  current serialized byte.
REQ-008 OutValid  output  1  OutData holds a valid byte.
REQ-009 OutReady  input  1  consumer accepts the byte; transfer occurs on a rising edge with OutValid=1 and OutReady=1.
REQ-010 Busy  output  1  a frame is captured and not yet fully sent.
REQ-011 Done  output  1  one-cycle pulse after the last byte of a frame transfers.
REQ-012 Missed  output  8  saturating count of Cap requests dropped while Busy.

Function
REQ-013 The block SHALL implement two states: IDLE and SEND.
REQ-014 In IDLE, Busy=0 and OutValid=0; OutData SHALL hold its last value.
REQ-015 IDLE, Cap=1 at an edge: the block SHALL latch Count0 and Count1 into a 128-bit shadow register, set the byte index to 0, and enter SEND. OutValid=1 and Busy=1 SHALL be visible in the following cycle (latency 1 cycle).
REQ-016 Frame = 16 bytes: indices 0-7 from shadow Count0, indices 8-15 from shadow Count1.
REQ-017 LSB_FIRST=1: index k of a word = bits[8k+7:8k]. LSB_FIRST=0: index k = bits[63-8k:56-8k].
REQ-018 In SEND, OutValid=1 and OutData = shadow byte[index] continuously.
REQ-019 OutData SHALL remain stable while OutValid=1 and OutReady=0. Count0/Count1 changes after capture SHALL NOT affect the frame.
REQ-020 Each transfer SHALL increment the index by 1. A transfer at index 15 SHALL return the block to IDLE, with OutValid=0 and Busy=0 in the next cycle.
REQ-021 Done SHALL be 1 for exactly the cycle after the index-15 transfer and 0 otherwise.
REQ-022 Cap=1 at any edge while in SEND, including the edge of the final transfer, SHALL be dropped and SHALL increment Missed. Missed saturates at 255 and does not wrap.
REQ-023 A held-high Cap in IDLE SHALL start exactly one frame per IDLE entry. A new frame may start on the first edge back in IDLE.
REQ-024 OutReady is ignored while OutValid=0.

Reset
REQ-025 While Reset=1, all of the following SHALL be 0: state=IDLE, OutValid, Busy, Done, OutData, Missed, index, and shadow register.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately with no Done pulse. After release, the block SHALL wait in IDLE for a new Cap.

Verification
REQ-027 Count0=64'h0123456789ABCDEF, Count1=64'hFEDCBA9876543210, LSB_FIRST=1, Cap pulse, OutReady=1 -> OutValid from the next cycle. Bytes EF,CD,AB,89,67,45,23,01,10,32,54,76,98,BA,DC,FE on 16 consecutive cycles. Done pulses once. Busy falls.
REQ-028 Same frame with LSB_FIRST=0 -> bytes 01,23,45,67,89,AB,CD,EF,FE,DC,BA,98,76,54,32,10.
REQ-029 OutReady toggled 1,0,0,1,... with Count0/Count1 incrementing every cycle after capture -> OutData stable during stalls. Frame equals the values captured at the Cap edge, with no lost or duplicated bytes.
REQ-030 Three Cap pulses during SEND, plus one on the final-transfer edge -> Missed=4, and no second frame starts. Missed driven past 255 -> Missed remains 255.
REQ-031 Reset asserted after byte 5 -> OutValid, Busy, and Missed are 0 immediately with no Done pulse. A Cap after release -> fresh frame starting at byte index 0.

Source files
------------

// File: rtl/count_snapshot_serializer.sv
// Snapshot serializer: on a capture request, freezes two 64-bit counter
// values into a 128-bit shadow register and streams them out as a 16-byte
// valid/ready frame. Capture requests that arrive mid-frame are dropped and
// tallied in a saturating 8-bit counter.
module count_snapshot_serializer #(
    parameter int LSB_FIRST = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Cap,
    input  logic [63:0] Count0,
    input  logic [63:0] Count1,
    output logic [7:0]  OutData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        Busy,
    output logic        Done,
    output logic [7:0]  Missed
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_SEND = 1'b1;

    logic [0:0]   state;
    logic [127:0] shadow;
    logic [3:0]   idx;
    logic [7:0]   last_byte;
    logic [7:0]   cur_byte;
    logic         xfer;
    logic         done_r;
    logic [7:0]   missed_r;

    // Byte k of the frame: indices 0-7 come from Count0, 8-15 from Count1.
    // For MSB-first order the byte offset within the word is 7-k, which for
    // a 3-bit k is simply its bitwise complement.
    function automatic logic [7:0] pick_byte(input logic [127:0] sh,
                                             input logic [3:0]   i);
        logic [63:0] word;
        logic [5:0]  sh_amt;
        word = i[3] ? sh[127:64] : sh[63:0];
        if (LSB_FIRST != 0)
            sh_amt = {i[2:0], 3'b000};
        else
            sh_amt = {~i[2:0], 3'b000};
        return 8'(word >> sh_amt);
    endfunction

    // Saturating increment: sticks at 255 rather than wrapping to 0.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign cur_byte = pick_byte(shadow, idx);
    assign xfer     = (state == STATE_SEND) && OutReady;

    assign OutValid = (state == STATE_SEND);
    assign Busy     = (state == STATE_SEND);
    // While idle the last byte sent stays on the bus.
    assign OutData  = (state == STATE_SEND) ? cur_byte : last_byte;
    assign Done     = done_r;
    assign Missed   = missed_r;

    // Frame control: capture in IDLE, advance the index on each transfer,
    // and fall back to IDLE after the 16th byte.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= STATE_IDLE;
            idx   <= 4'd0;
        end else if (state == STATE_IDLE) begin
            if (Cap) begin
                state <= STATE_SEND;
                idx   <= 4'd0;
            end
        end else if (xfer) begin
            idx <= idx + 4'd1;
            if (idx == 4'd15)
                state <= STATE_IDLE;
        end
    end

    // Snapshot both counters at the capture edge; later input changes are ignored.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            shadow <= '0;
        else if ((state == STATE_IDLE) && Cap)
            shadow <= {Count1, Count0};
    end

    // Remember the most recently transferred byte for the idle-hold behaviour.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            last_byte <= 8'd0;
        else if (xfer)
            last_byte <= cur_byte;
    end

    // One-cycle completion pulse following the final transfer.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            done_r <= 1'b0;
        else
            done_r <= xfer && (idx == 4'd15);
    end

    // Count capture requests that arrive while a frame is in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            missed_r <= 8'd0;
        else if ((state == STATE_SEND) && Cap)
            missed_r <= sat_inc(missed_r);
    end

endmodule

// File: tb/tb_count_snapshot_serializer.sv
// Bench for count_snapshot_serializer: runs an LSB-first and an MSB-first
// instance side by side against a protocol-level reference model with
// per-instance byte queues.
module tb_count_snapshot_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cap = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] count0 = '0;
    logic [63:0] count1 = '0;

    logic [7:0]  data_l, data_m, missed_l, missed_m;
    logic        valid_l, valid_m, busy_l, busy_m, done_l, done_m;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q_l[$];
    logic [7:0] q_m[$];
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    int         m_left = 0;
    int         m_missed = 0;
    logic [7:0] m_last_l = 8'd0;
    logic [7:0] m_last_m = 8'd0;

    count_snapshot_serializer #(.LSB_FIRST(1)) u_lsb (
        .Clk(clk), .Reset(reset), .Cap(cap), .Count0(count0), .Count1(count1),
        .OutData(data_l), .OutValid(valid_l), .OutReady(out_ready),
        .Busy(busy_l), .Done(done_l), .Missed(missed_l)
    );

    count_snapshot_serializer #(.LSB_FIRST(0)) u_msb (
        .Clk(clk), .Reset(reset), .Cap(cap), .Count0(count0), .Count1(count1),
        .OutData(data_m), .OutValid(valid_m), .OutReady(out_ready),
        .Busy(busy_m), .Done(done_m), .Missed(missed_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Expected byte streams for both orders, built by shifting whole words.
    task automatic push_frame(input logic [63:0] c0, input logic [63:0] c1);
        logic [63:0] a, b;
        a = c0; b = c0;
        for (int i = 0; i < 8; i++) begin
            q_l.push_back(a[7:0]);   a = a >> 8;
            q_m.push_back(b[63:56]); b = b << 8;
        end
        a = c1; b = c1;
        for (int i = 0; i < 8; i++) begin
            q_l.push_back(a[7:0]);   a = a >> 8;
            q_m.push_back(b[63:56]); b = b << 8;
        end
    endtask

    // Compare outputs mid-cycle, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            q_l.delete(); q_m.delete();
            m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_missed = 0;
            m_last_l = 8'd0; m_last_m = 8'd0;
        end
        chk("valid_l", valid_l, m_busy);
        chk("valid_m", valid_m, m_busy);
        chk("busy_l", busy_l, m_busy);
        chk("busy_m", busy_m, m_busy);
        chk("done_l", done_l, m_done);
        chk("done_m", done_m, m_done);
        chk("missed_l", missed_l, m_missed);
        chk("missed_m", missed_m, m_missed);
        if (m_busy) begin
            chk("queue_nonempty", (q_l.size() > 0) && (q_m.size() > 0), 1);
            if (q_l.size() > 0 && q_m.size() > 0) begin
                chk("byte_l", data_l, q_l[0]);
                chk("byte_m", data_m, q_m[0]);
            end
        end else begin
            chk("hold_l", data_l, m_last_l);
            chk("hold_m", data_m, m_last_m);
        end
        if (!reset) begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (cap) begin
                    push_frame(count0, count1);
                    m_busy = 1'b1;
                    m_left = 16;
                end
            end else begin
                if (cap && m_missed < 255)
                    m_missed++;
                if (out_ready && q_l.size() > 0 && q_m.size() > 0) begin
                    m_last_l = q_l.pop_front();
                    m_last_m = q_m.pop_front();
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy_l || busy_m) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, busy_l | busy_m, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_data_l", data_l, 0);
        chk("rst_data_m", data_m, 0);
        chk("rst_valid", valid_l, 0);
        chk("rst_missed", missed_l, 0);
        reset = 1'b0;
        tick();

        // Full-speed frame, both byte orders; inputs change right after capture
        count0 = 64'h0123456789ABCDEF;
        count1 = 64'hFEDCBA9876543210;
        out_ready = 1'b1;
        cap = 1'b1;
        tick();
        cap = 1'b0;
        count0 = 64'h0;
        count1 = 64'h0;
        chk("latency_valid", valid_l, 1);
        chk("latency_busy", busy_m, 1);
        chk("first_byte_l", data_l, 64'hEF);
        chk("first_byte_m", data_m, 64'h01);
        wait_idle("frame1_timeout", 40);
        repeat (3) tick();

        // Stalled frame with counters moving every cycle
        count0 = 64'h1122334455667788;
        count1 = 64'h99AABBCCDDEEFF00;
        cap = 1'b1;
        tick();
        cap = 1'b0;
        begin
            int c;
            c = 0;
            while (busy_l && c < 200) begin
                out_ready = (c % 3 == 0);
                count0 = count0 + 64'd1;
                count1 = count1 + 64'd1;
                tick();
                c++;
            end
            chk("stall_timeout", busy_l, 0);
        end
        out_ready = 1'b1;
        repeat (2) tick();

        // Drops during SEND, including the final-transfer edge
        count0 = 64'hA5A5A5A5_5A5A5A5A;
        count1 = 64'h0F0F0F0F_F0F0F0F0;
        cap = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            cap = (i == 3 || i == 6 || i == 9 || i == 16);
            tick();
        end
        cap = 1'b0;
        repeat (3) tick();
        chk("missed4_l", missed_l, 4);
        chk("missed4_m", missed_m, 4);
        chk("no_second_frame", busy_l, 0);

        // Held capture: back-to-back frames, drop counter saturates
        cap = 1'b1;
        for (int i = 0; i < 320; i++) begin
            count0 = count0 + 64'd3;
            count1 = count1 - 64'd5;
            tick();
        end
        cap = 1'b0;
        wait_idle("sat_timeout", 40);
        chk("missed_sat_l", missed_l, 255);
        chk("missed_sat_m", missed_m, 255);
        repeat (2) tick();

        // Asynchronous reset after byte 5, then a fresh frame
        count0 = 64'h0807060504030201;
        count1 = 64'h100F0E0D0C0B0A09;
        cap = 1'b1;
        tick();
        cap = 1'b0;
        repeat (6) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("abort_valid", valid_l, 0);
        chk("abort_busy", busy_m, 0);
        chk("abort_missed", missed_l, 0);
        chk("abort_done", done_l, 0);
        chk("abort_data", data_m, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        count0 = 64'hDEADBEEFCAFEF00D;
        count1 = 64'h0011223344556677;
        cap = 1'b1;
        tick();
        cap = 1'b0;
        chk("restart_byte0_l", data_l, 64'h0D);
        chk("restart_byte0_m", data_m, 64'hDE);
        wait_idle("restart_timeout", 40);
        repeat (3) tick();
        chk("queue_empty_l", q_l.size(), 0);
        chk("queue_empty_m", q_m.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
